// File: rtl/ram_4x8.sv
// ram_4x8: 4-word x 8-bit flip-flop register-file RAM.
// Synchronous write, combinational read, shared address, async active-low clear.
module ram_4x8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] D,
    output logic [7:0] Q,
    input  logic [1:0] addr,
    input  logic       we
);

    localparam int WORDS = 4;
    localparam int WIDTH = 8;
    localparam int AW    = 2;

    logic [WIDTH-1:0] mem [WORDS];
    logic [WORDS-1:0] wsel;

    // One-hot word select, gated by we so at most one word is written.
    always_comb begin
        wsel = '0;
        unique case (addr)
            AW'(0): wsel[0] = we;
            AW'(1): wsel[1] = we;
            AW'(2): wsel[2] = we;
            AW'(3): wsel[3] = we;
            default: wsel = '0;
        endcase
    end

    for (genvar i = 0; i < WORDS; i++) begin : g_word
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem[i] <= '0;
            end else if (wsel[i]) begin
                mem[i] <= D;
            end
        end
    end

    // Read mux sees storage directly: no bypass of D before the edge.
    always_comb begin
        Q = '0;
        unique case (addr)
            AW'(0): Q = mem[0];
            AW'(1): Q = mem[1];
            AW'(2): Q = mem[2];
            AW'(3): Q = mem[3];
            default: Q = '0;
        endcase
    end

endmodule

// File: tb/tb_ram_4x8.sv
// tb_ram_4x8: directed and randomized checks of ram_4x8 against
// an array reference model of the storage.
module tb_ram_4x8;

    logic       clk;
    logic       rst_n;
    logic [7:0] D;
    logic [7:0] Q;
    logic [1:0] addr;
    logic       we;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ref_mem [4];

    ram_4x8 dut (
        .clk  (clk),
        .rst_n(rst_n),
        .D    (D),
        .Q    (Q),
        .addr (addr),
        .we   (we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] exp);
        n_tests++;
        assert (Q === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, Q, exp);
        end
    endtask

    task automatic read_all(input string tag);
        we = 1'b0;
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            check($sformatf("%s_a%0d", tag, a), ref_mem[a]);
        end
    endtask

    // Drive at negedge, apply one rising edge, update model afterwards.
    task automatic cycle(input logic w, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        we   = w;
        addr = a;
        D    = d;
        @(posedge clk);
        #1;
        if (w && rst_n) ref_mem[a] = d;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) ref_mem[i] = 8'h00;
        rst_n = 1'b0;
        we    = 1'b1;
        D     = 8'($urandom);
        addr  = 2'($urandom);

        // Reset held: writes ignored, everything reads zero.
        repeat (3) begin
            @(negedge clk);
            D    = 8'($urandom);
            addr = 2'($urandom);
            we   = 1'b1;
        end
        @(posedge clk);
        #1;
        read_all("rst_low");

        @(negedge clk);
        we    = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        read_all("rst_rel");

        // Sequential fill, then combinational readback.
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), 8'(i));
        read_all("fill");

        // Hold with we=0.
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'd2, 8'hFF);
        check("hold_a2", 8'h02);
        read_all("hold");

        // Read during write: old data before edge, new after.
        @(negedge clk);
        addr = 2'd1;
        D    = 8'hA5;
        we   = 1'b1;
        #1;
        check("rdw_before", 8'h01);
        @(posedge clk);
        #1;
        ref_mem[1] = 8'hA5;
        check("rdw_after", 8'hA5);
        read_all("rdw");

        // Restore word 1 and check overwrite isolation.
        cycle(1'b1, 2'd1, 8'h01);
        cycle(1'b1, 2'd3, 8'h5A);
        cycle(1'b1, 2'd0, 8'hC3);
        read_all("ovr");

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            logic [1:0] ra;
            cycle(1'($urandom), 2'($urandom), 8'($urandom));
            we = 1'b0;
            ra = 2'($urandom);
            addr = ra;
            #1;
            check($sformatf("rnd%0d", k), ref_mem[ra]);
        end
        read_all("rnd_end");

        // Async reset pulse between edges, in the middle of a write cycle.
        @(negedge clk);
        addr = 2'd3;
        D    = 8'h77;
        we   = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) ref_mem[i] = 8'h00;
        check("async_rst_now", 8'h00);
        @(posedge clk);
        #1;
        read_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        we    = 1'b0;
        @(posedge clk);
        #1;
        read_all("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
